// File: rtl/hwpe_stream_tcdm_fifo_store_if.sv
// Shared types and the TCDM port interface used by the store FIFO.
// On this port wen=1 marks a store request.
package hwpe_stream_package;

   typedef struct packed {
      logic       empty;
      logic       full;
      logic [7:0] push_pointer;
      logic [7:0] pop_pointer;
   } flags_fifo_t;

endpackage

interface hwpe_stream_intf_tcdm;

   logic        req;
   logic        gnt;
   logic [31:0] add;
   logic        wen;
   logic [3:0]  be;
   logic [31:0] data;
   logic [31:0] r_data;
   logic        r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );

endinterface

// File: rtl/hwpe_stream_tcdm_fifo_store.sv
// TCDM store decoupling buffer: grants streamer stores locally, replays them to the
// interconnect in order, and counts stores still waiting for a write response.
module hwpe_stream_fifo #(
   parameter int unsigned DATA_WIDTH = 68,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LATCH_FIFO = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   if (LATCH_FIFO != 0) begin : gen_latch
      // Writes are staged in flops and land in the latches during the low clock phase.
      logic                  we_q, we_d;
      logic [PTR_W-1:0]      waddr_q, waddr_d;
      logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

      always_comb begin
         we_d    = push_ok & ~clear_i;
         waddr_d = wr_ptr_q;
         wdata_d = push_data_i;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
         end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
         end
      end

      always_latch begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (!clk_i && we_q && (waddr_q == PTR_W'(i))) mem[i] <= wdata_q;
         end
      end

      assign pop_data_o = mem[rd_ptr_q];
   end else begin : gen_ff
      logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

      always_ff @(posedge clk_i) begin
         if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
      end

      assign pop_data_o = mem_q[rd_ptr_q];
   end

endmodule

module hwpe_stream_tcdm_fifo_store
   import hwpe_stream_package::*;
#(
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned LATCH_FIFO      = 0,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   output flags_fifo_t                 flags_o,
   hwpe_stream_intf_tcdm.slave         tcdm_slave,
   hwpe_stream_intf_tcdm.master        tcdm_master
);

   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic             r_valid_q, r_valid_d;
   logic             fifo_full, fifo_empty;
   logic             push, pop, rsp;
   logic [67:0]      push_data, pop_data;
   logic             unused_r_data;

   // Grant depends only on local state so a master pop never opens a full buffer in the same cycle.
   assign tcdm_slave.gnt     = ~fifo_full & tcdm_slave.wen;
   assign tcdm_slave.r_data  = '0;
   assign tcdm_slave.r_valid = r_valid_q;
   assign push               = tcdm_slave.req & tcdm_slave.gnt;
   assign push_data          = {tcdm_slave.add, tcdm_slave.data, tcdm_slave.be};

   assign tcdm_master.req = ~fifo_empty & (outstanding_q < OUT_MAX);
   assign tcdm_master.wen = 1'b1;
   assign {tcdm_master.add, tcdm_master.data, tcdm_master.be} = pop_data;
   assign pop             = tcdm_master.req & tcdm_master.gnt;
   assign unused_r_data   = ^tcdm_master.r_data;

   hwpe_stream_fifo #(
      .DATA_WIDTH (68),
      .FIFO_DEPTH (FIFO_DEPTH),
      .LATCH_FIFO (LATCH_FIFO)
   ) i_store_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .pop_data_o  (pop_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // A response with nothing outstanding (e.g. one arriving after a clear) is dropped.
   always_comb begin
      rsp           = tcdm_master.r_valid & (outstanding_q != '0);
      outstanding_d = outstanding_q;
      r_valid_d     = push;
      if (clear_i) begin
         outstanding_d = '0;
         r_valid_d     = 1'b0;
      end else if (pop && !rsp) begin
         outstanding_d = outstanding_q + OUT_W'(1);
      end else if (rsp && !pop) begin
         outstanding_d = outstanding_q - OUT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
         r_valid_q     <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         r_valid_q     <= r_valid_d;
      end
   end

   always_comb begin
      flags_o       = '0;
      flags_o.empty = fifo_empty & (outstanding_q == '0);
      flags_o.full  = fifo_full;
   end

   a_store_only: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tcdm_slave.req |-> tcdm_slave.wen)
      else $error("read request on store-only TCDM port is never granted");

endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_store.sv
// Scoreboard bench for the TCDM store FIFO: a cycle model predicts handshakes and flags,
// and a queue of granted stores is compared against what the master port replays.
module tb_hwpe_stream_tcdm_fifo_store;
   import hwpe_stream_package::*;

   localparam int FIFO_DEPTH      = 8;
   localparam int MAX_OUTSTANDING = 4;

   logic        clk = 1'b0;
   logic        rst_n, clear;
   logic        s_req, s_wen;
   logic [31:0] s_add, s_data;
   logic [3:0]  s_be;
   logic        m_gnt, rv_man, rv_auto, rsp_auto;
   flags_fifo_t flags;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          occ, outc;
   logic        sv_exp, hs_last;
   logic        e_sgnt, e_mreq, e_push, e_pop, e_rsp;
   logic [67:0] sb[$];

   hwpe_stream_intf_tcdm slave_if();
   hwpe_stream_intf_tcdm master_if();

   assign slave_if.req       = s_req;
   assign slave_if.wen       = s_wen;
   assign slave_if.add       = s_add;
   assign slave_if.data      = s_data;
   assign slave_if.be        = s_be;
   assign master_if.gnt      = m_gnt;
   assign master_if.r_valid  = rv_auto | rv_man;
   assign master_if.r_data   = '0;

   hwpe_stream_tcdm_fifo_store #(
      .FIFO_DEPTH      (FIFO_DEPTH),
      .LATCH_FIFO      (0),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .flags_o     (flags),
      .tcdm_slave  (slave_if),
      .tcdm_master (master_if)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [67:0] obs, input logic [67:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Interconnect stand-in: answers each grant one cycle later when auto responses are on.
   always begin
      @(posedge clk);
      #2;
      rv_auto = rsp_auto & hs_last;
   end

   // Cycle model sampled mid-cycle; its state update predicts the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         occ = 0; outc = 0; sv_exp = 1'b0; hs_last = 1'b0;
         sb.delete();
      end else begin
         e_sgnt = (occ < FIFO_DEPTH) && s_wen;
         e_mreq = (occ > 0) && (outc < MAX_OUTSTANDING);
         checkOutput("s_gnt", 68'(slave_if.gnt), 68'(e_sgnt));
         checkOutput("m_req", 68'(master_if.req), 68'(e_mreq));
         checkOutput("s_rvalid", 68'(slave_if.r_valid), 68'(sv_exp));
         checkOutput("s_rdata", 68'(slave_if.r_data), 68'(0));
         checkOutput("flag_empty", 68'(flags.empty), 68'((occ == 0) && (outc == 0)));
         checkOutput("flag_full", 68'(flags.full), 68'(occ == FIFO_DEPTH));
         e_push = s_req && e_sgnt;
         e_pop  = e_mreq && m_gnt;
         e_rsp  = master_if.r_valid && (outc > 0);
         if (e_push) sb.push_back({s_add, s_data, s_be});
         if (e_pop) begin
            checkOutput("m_payload", {master_if.add, master_if.data, master_if.be}, sb.pop_front());
            checkOutput("m_wen", 68'(master_if.wen), 68'(1));
         end
         hs_last = e_pop;
         if (clear) begin
            occ = 0; outc = 0; sv_exp = 1'b0;
            sb.delete();
         end else begin
            occ = occ + int'(e_push) - int'(e_pop);
            if (e_pop && !e_rsp) outc++;
            else if (e_rsp && !e_pop) outc--;
            sv_exp = e_push;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one store and returns just after the edge that accepted it.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int waited = 0;
      s_req = 1'b1; s_wen = 1'b1; s_add = a; s_data = d; s_be = b;
      @(negedge clk);
      while (!slave_if.gnt && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!slave_if.gnt) checkOutput("stim_gnt_timeout", 68'(slave_if.gnt), 68'(1));
      @(posedge clk);
      #1;
      s_req = 1'b0;
   endtask

   task automatic waitEmpty(input string tag);
      int n = 0;
      @(negedge clk);
      while (!flags.empty && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 68'(flags.empty), 68'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run still active at 200000, expected finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0;
      s_req = 1'b0; s_wen = 1'b1; s_add = '0; s_data = '0; s_be = '0;
      m_gnt = 1'b0; rv_man = 1'b0; rv_auto = 1'b0; rsp_auto = 1'b0;

      @(negedge clk);
      checkOutput("rst_active_mreq", 68'(master_if.req), 68'(0));
      idle(2);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_gnt", 68'(slave_if.gnt), 68'(1));
      checkOutput("rst_rvalid", 68'(slave_if.r_valid), 68'(0));
      checkOutput("rst_rdata", 68'(slave_if.r_data), 68'(0));
      checkOutput("rst_mreq", 68'(master_if.req), 68'(0));
      checkOutput("rst_empty", 68'(flags.empty), 68'(1));
      checkOutput("rst_full", 68'(flags.full), 68'(0));
      idle(1);

      $display("[TB] basic in-order stores");
      m_gnt = 1'b1; rsp_auto = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      waitEmpty("t1_empty_after_rsp");
      checkOutput("t1_sb_drained", 68'(sb.size()), 68'(0));

      $display("[TB] full buffer with master stalled");
      m_gnt = 1'b0;
      for (int i = 0; i < 8; i++) applyStimulus(32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 4'(i + 1));
      s_req = 1'b1; s_wen = 1'b1; s_add = 32'h320; s_data = 32'hB8; s_be = 4'h3;
      repeat (3) begin
         @(negedge clk);
         checkOutput("t2_ninth_stalled", 68'(slave_if.gnt), 68'(0));
         checkOutput("t2_full_flag", 68'(flags.full), 68'(1));
      end
      idle(1);
      m_gnt = 1'b1;
      @(negedge clk);
      checkOutput("t2_gnt_during_pop", 68'(slave_if.gnt), 68'(0));
      idle(1);
      @(negedge clk);
      checkOutput("t2_ninth_granted", 68'(slave_if.gnt), 68'(1));
      idle(1);
      s_req = 1'b0;
      waitEmpty("t2_empty_after_drain");

      $display("[TB] outstanding limit");
      rsp_auto = 1'b0;
      for (int i = 0; i < 6; i++) applyStimulus(32'h400 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF);
      idle(3);
      @(negedge clk);
      checkOutput("t3_req_capped", 68'(master_if.req), 68'(0));
      checkOutput("t3_not_empty", 68'(flags.empty), 68'(0));
      idle(1);
      rv_man = 1'b1;
      idle(1);
      rv_man = 1'b0;
      @(negedge clk);
      checkOutput("t3_req_reenabled", 68'(master_if.req), 68'(1));
      idle(1);
      m_gnt = 1'b0; rv_man = 1'b1;
      idle(2);
      m_gnt = 1'b1;
      @(negedge clk);
      checkOutput("t4_req_same_cycle", 68'(master_if.req), 68'(1));
      idle(1);
      m_gnt = 1'b0; rv_man = 1'b0;
      @(negedge clk);
      checkOutput("t4_cnt2_not_empty", 68'(flags.empty), 68'(0));
      idle(1);
      rv_man = 1'b1;
      idle(1);
      rv_man = 1'b0;
      @(negedge clk);
      checkOutput("t4_cnt1_not_empty", 68'(flags.empty), 68'(0));
      idle(1);
      rv_man = 1'b1;
      idle(1);
      rv_man = 1'b0;
      @(negedge clk);
      checkOutput("t4_cnt0_empty", 68'(flags.empty), 68'(1));
      idle(1);

      $display("[TB] random grants and responses");
      for (int i = 0; i < 3; i++) applyStimulus(32'h500 + 32'(4 * i), 32'hD0 + 32'(i), 4'hC);
      for (int i = 0; i < 10; i++) begin
         m_gnt  = 1'($urandom_range(0, 1));
         rv_man = 1'($urandom_range(0, 1));
         idle(1);
      end
      m_gnt = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (occ == 0 && outc == 0) break;
         rv_man = (outc > 0);
         idle(1);
      end
      rv_man = 1'b0; m_gnt = 1'b0;
      @(negedge clk);
      checkOutput("t4_empty_after_random", 68'(flags.empty), 68'(1));
      idle(1);

      $display("[TB] soft clear");
      for (int i = 0; i < 8; i++) applyStimulus(32'h600 + 32'(4 * i), 32'hE0 + 32'(i), 4'h5);
      m_gnt = 1'b1;
      idle(3);
      m_gnt = 1'b0;
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      @(negedge clk);
      checkOutput("t5_clr_req", 68'(master_if.req), 68'(0));
      checkOutput("t5_clr_empty", 68'(flags.empty), 68'(1));
      checkOutput("t5_clr_gnt", 68'(slave_if.gnt), 68'(1));
      idle(1);
      rv_man = 1'b1;
      idle(3);
      rv_man = 1'b0;
      @(negedge clk);
      checkOutput("t5_late_rvalid_empty", 68'(flags.empty), 68'(1));
      checkOutput("t5_late_rvalid_req", 68'(master_if.req), 68'(0));
      idle(1);
      rsp_auto = 1'b1; m_gnt = 1'b1;
      applyStimulus(32'h700, 32'hF0, 4'h9);
      waitEmpty("t5_recover_empty");

      $display("[TB] load request never granted");
      s_wen = 1'b0; s_add = 32'h200; s_data = '0; s_be = 4'hF;
      repeat (3) begin
         @(negedge clk);
         checkOutput("t6_wen0_gnt", 68'(slave_if.gnt), 68'(0));
         checkOutput("t6_wen0_mreq", 68'(master_if.req), 68'(0));
      end
      idle(1);
      s_wen = 1'b1;
      idle(2);
      checkOutput("sb_empty_at_end", 68'(sb.size()), 68'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hwpe_stream_tcdm_fifo_store.md
Name: hwpe_stream_tcdm_fifo_store

Overview:
- Decoupling buffer for the TCDM store path; write-side counterpart of the load FIFO.
- Accepts store requests from an HWPE streamer on a TCDM slave port and grants them locally while buffer space exists.
- Replays buffered stores to the cluster interconnect on a TCDM master port.
- Tracks outstanding interconnect write responses so the engine knows when all stores have landed.

Parameters:
- FIFO_DEPTH, 8: store buffer entries; power of two, >=2.
- LATCH_FIFO, 0: 1 selects latch-based storage in the internal hwpe_stream_fifo.
- MAX_OUTSTANDING, 4: maximum granted-but-unacknowledged stores on the master side; >=1.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous reset, active low.
- clear_i  input  1  synchronous soft clear.
- flags_o  output  flags_fifo_t  .empty = buffer empty and no outstanding stores; .full = buffer full; all other fields driven '0.
- tcdm_slave  hwpe_stream_intf_tcdm.slave  32b add/data, 4b be  store requests from the streamer.
- tcdm_master  hwpe_stream_intf_tcdm.master  32b add/data, 4b be  stores towards the interconnect.

Behaviour:
- Reset / clear: clear_i takes effect at the next edge and has the same effect as rst_ni.
  - Empties the buffer, zeroes the outstanding counter, drops the pending slave ack.
  - Master r_valid arriving after a clear is ignored; the counter does not underflow.
  - After reset: tcdm_slave.gnt=1, tcdm_slave.r_valid=0, tcdm_slave.r_data=0, tcdm_master.req=0, flags_o.empty=1, flags_o.full=0.
- Slave side:
  - gnt = buffer not full & wen. Stores only: a req with wen=0 is never granted (simulation assertion fires).
  - On a req&gnt cycle, {add, data, be} is pushed into a 68-bit internal hwpe_stream_fifo.
  - tcdm_slave.r_valid is asserted exactly one cycle after each slave grant.
  - r_data is constant 0.
  - Back-to-back grants give back-to-back r_valid.
- Master side:
  - req = buffer not empty & (outstanding < MAX_OUTSTANDING).
  - add/data/be come from the buffer head; wen=1.
  - A master gnt pops the head; req may then stay high for the next entry in the same cycle.
  - Entries drain in strict FIFO order.
- Outstanding counter (width clog2(MAX_OUTSTANDING+1)):
  - +1 on master req&gnt; -1 on master r_valid; unchanged if both occur in the same cycle.
  - Saturates at 0 on a spurious r_valid.
- Latency: a store granted at cycle t can be requested on the master at cycle t+1 at the earliest (no combinational slave->master path).
- Full: when the buffer is full, slave gnt=0. If the master pops in the same cycle, gnt still stays 0 (gnt does not depend on master gnt).
- Empty: master req=0. A simultaneous push and pop with one entry keeps occupancy at 1.
- flags_o.empty falls the cycle after the first slave grant. It rises only after the last master r_valid has been registered and the buffer is empty.
- Throughput: 1 store/cycle sustained if the master grants every cycle and responses return within MAX_OUTSTANDING cycles.

Test Plan:
- Reset, then 4 stores to 0x100,0x104,0x108,0x10C (data 0xA0..0xA3, be 0xF), master gnt=1, r_valid one cycle later.
  - Required: master sees the same four add/data/be in order, first req at grant+1.
  - Required: slave r_valid 1 cycle after each grant; flags_o.empty=1 after the last response.
- Master gnt held 0, 9 slave store requests with FIFO_DEPTH=8.
  - Required: 8 granted, 9th stalls with gnt=0 and flags_o.full=1.
  - Release gnt: the 9th store is granted the cycle after the first pop frees space.
- Master gnt=1, r_valid withheld.
  - Required: after MAX_OUTSTANDING=4 grants, master req drops to 0 with entries still buffered.
  - Required: one r_valid re-enables req the next cycle.
- Master gnt and r_valid in the same cycle with counter=2.
  - Required: counter stays 2; 10 cycles of random gnt/r_valid leave the counter equal to grants minus responses.
- clear_i asserted with 5 buffered stores and 3 outstanding.
  - Required: next cycle req=0, empty=1, gnt=1.
  - Required: late r_valid pulses are ignored and the counter stays 0.
- Slave req with wen=0 at 0x200.
  - Required: gnt never asserted, no master traffic, assertion reported.
